// File: rtl/pipe_ctrl_pkg.sv
// Shared types and encodings for the ID-stage pipeline controller.
package pipe_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SLL = 5'b00001;
    localparam logic [4:0] ALU_SRL = 5'b00101;
    localparam logic [4:0] ALU_SUB = 5'b10000;
    localparam logic [4:0] ALU_SRA = 5'b10101;
    localparam logic [4:0] ALU_FWD = 5'b11110;
    localparam logic [4:0] ALU_JMP = 5'b10001;

    localparam logic [2:0] MEM_NONE = 3'b000;
    localparam logic [2:0] MEM_B    = 3'b001;
    localparam logic [2:0] MEM_H    = 3'b010;
    localparam logic [2:0] MEM_W    = 3'b011;
    localparam logic [2:0] MEM_BU   = 3'b100;
    localparam logic [2:0] MEM_HU   = 3'b101;

    localparam logic [2:0] IMM_NONE = 3'b000;
    localparam logic [2:0] IMM_I    = 3'b001;
    localparam logic [2:0] IMM_S    = 3'b010;
    localparam logic [2:0] IMM_B    = 3'b011;
    localparam logic [2:0] IMM_U    = 3'b100;
    localparam logic [2:0] IMM_J    = 3'b101;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [1:0] SRC_RS2    = 2'b00;
    localparam logic [1:0] SRC_IMM    = 2'b01;
    localparam logic [1:0] SRC_PC_IMM = 2'b10;

    typedef struct packed {
        logic [4:0] alu_op;
        logic [2:0] mem_read;
        logic [2:0] mem_write;
        logic [2:0] immi_sel;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_source;
        logic       reg_write;
        logic       branch;
        logic       pc_sel;
        logic [4:0] rd;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_BUBBLE = '0;

    typedef enum logic {
        ST_IDLE,
        ST_MD_WAIT
    } state_t;

    // MEM_NONE doubles as the "unlisted funct3" marker for loads.
    function automatic logic [2:0] load_type(input logic [2:0] funct3);
        case (funct3)
            3'b000:  load_type = MEM_B;
            3'b001:  load_type = MEM_H;
            3'b010:  load_type = MEM_W;
            3'b100:  load_type = MEM_BU;
            3'b101:  load_type = MEM_HU;
            default: load_type = MEM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/pipe_ctrl_unit_rv_decode.sv
// Combinational RV32IM decoder: instruction word to control bundle plus hazard/occupancy hints.
module rv_decode
    import pipe_ctrl_pkg::*;
#(
    parameter bit EN_MEXT = 1'b1
) (
    input  logic [31:0]  instr_i,
    output ctrl_bundle_t ctrl_o,
    output logic         illegal_o,
    output logic         is_md_o,
    output logic         md_div_o,
    output logic         uses_rs2_o,
    output logic [4:0]   rs1_o,
    output logic [4:0]   rs2_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       bad;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign rs1_o  = instr_i[19:15];
    assign rs2_o  = instr_i[24:20];

    always_comb begin
        ctrl_o     = CTRL_BUBBLE;
        ctrl_o.rd  = instr_i[11:7];
        bad        = 1'b0;
        is_md_o    = 1'b0;
        md_div_o   = funct3[2];
        uses_rs2_o = 1'b0;

        case (opcode)
            OP_R: begin
                uses_rs2_o       = 1'b1;
                ctrl_o.reg_write = 1'b1;
                if (funct7 == F7_BASE) begin
                    ctrl_o.alu_op = {2'b00, funct3};
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    ctrl_o.alu_op = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    ctrl_o.alu_op = ALU_SRA;
                end else if (funct7 == F7_MEXT && EN_MEXT) begin
                    ctrl_o.alu_op = {2'b11, funct3};
                    is_md_o       = 1'b1;
                end else begin
                    bad = 1'b1;
                end
            end
            OP_IALU: begin
                ctrl_o.immi_sel   = IMM_I;
                ctrl_o.alu_source = SRC_IMM;
                ctrl_o.reg_write  = 1'b1;
                case (funct3)
                    3'b001: begin
                        ctrl_o.alu_op = ALU_SLL;
                        bad           = (funct7 != F7_BASE);
                    end
                    3'b101: begin
                        if (funct7 == F7_BASE)     ctrl_o.alu_op = ALU_SRL;
                        else if (funct7 == F7_ALT) ctrl_o.alu_op = ALU_SRA;
                        else                       bad = 1'b1;
                    end
                    default: ctrl_o.alu_op = {2'b00, funct3};
                endcase
            end
            OP_LOAD: begin
                ctrl_o.mem_read   = load_type(funct3);
                ctrl_o.immi_sel   = IMM_I;
                ctrl_o.alu_source = SRC_IMM;
                ctrl_o.mem_to_reg = WB_MEM;
                ctrl_o.reg_write  = 1'b1;
                bad               = (ctrl_o.mem_read == MEM_NONE);
            end
            OP_STORE: begin
                uses_rs2_o        = 1'b1;
                ctrl_o.mem_write  = funct3 + 3'd1;
                ctrl_o.immi_sel   = IMM_S;
                ctrl_o.alu_source = SRC_IMM;
                bad               = (funct3 > 3'b010);
            end
            OP_BRANCH: begin
                uses_rs2_o      = 1'b1;
                ctrl_o.alu_op   = {2'b01, funct3};
                ctrl_o.branch   = 1'b1;
                ctrl_o.immi_sel = IMM_B;
                bad             = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OP_JAL: begin
                ctrl_o.alu_op     = ALU_JMP;
                ctrl_o.immi_sel   = IMM_J;
                ctrl_o.mem_to_reg = WB_PC4;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.pc_sel     = 1'b1;
            end
            OP_JALR: begin
                ctrl_o.alu_op     = ALU_JMP;
                ctrl_o.immi_sel   = IMM_I;
                ctrl_o.alu_source = SRC_IMM;
                ctrl_o.mem_to_reg = WB_PC4;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.pc_sel     = 1'b1;
                bad               = (funct3 != 3'b000);
            end
            OP_LUI: begin
                ctrl_o.alu_op     = ALU_FWD;
                ctrl_o.immi_sel   = IMM_U;
                ctrl_o.alu_source = SRC_IMM;
                ctrl_o.reg_write  = 1'b1;
            end
            OP_AUIPC: begin
                ctrl_o.alu_op     = ALU_ADD;
                ctrl_o.immi_sel   = IMM_U;
                ctrl_o.alu_source = SRC_PC_IMM;
                ctrl_o.reg_write  = 1'b1;
            end
            default: bad = 1'b1;
        endcase

        if (bad) begin
            ctrl_o  = CTRL_BUBBLE;
            is_md_o = 1'b0;
        end
    end

    assign illegal_o = bad;

endmodule

// File: rtl/pipe_ctrl_unit.sv
// ID-stage controller: registered ID/EX bundle, load-use stall and MUL/DIV occupancy sequencing.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter bit EN_MEXT = 1'b1,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] INSTR,
    input  logic        IN_VALID,
    input  logic        FLUSH,
    output logic        STALL,
    output logic        OUT_VALID,
    output logic [4:0]  ALU_OP,
    output logic [2:0]  MEM_READ,
    output logic [2:0]  MEM_WRITE,
    output logic [2:0]  IMMI_SEL,
    output logic [1:0]  MEM_TO_REG,
    output logic [1:0]  ALU_SOURCE,
    output logic        REG_WRITE,
    output logic        BRANCH,
    output logic        PC_SEL,
    output logic [4:0]  RD,
    output logic        ILLEGAL
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = ($clog2(MAX_LAT) > 0) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    ctrl_bundle_t     dec_ctrl;
    logic             dec_illegal;
    logic             dec_is_md;
    logic             dec_md_div;
    logic             dec_uses_rs2;
    logic [4:0]       dec_rs1;
    logic [4:0]       dec_rs2;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    ctrl_bundle_t     bundle_q;
    logic             valid_q;
    logic             illegal_q;

    logic             hazard;
    logic             md_multi;

    rv_decode #(
        .EN_MEXT (EN_MEXT)
    ) u_decode (
        .instr_i    (INSTR),
        .ctrl_o     (dec_ctrl),
        .illegal_o  (dec_illegal),
        .is_md_o    (dec_is_md),
        .md_div_o   (dec_md_div),
        .uses_rs2_o (dec_uses_rs2),
        .rs1_o      (dec_rs1),
        .rs2_o      (dec_rs2)
    );

    // Compare against the instruction issued last cycle; bubbles never match.
    assign hazard = IN_VALID && valid_q
                 && (bundle_q.mem_read != MEM_NONE) && (bundle_q.rd != 5'd0)
                 && ((bundle_q.rd == dec_rs1) || (dec_uses_rs2 && (bundle_q.rd == dec_rs2)));

    assign md_multi = dec_md_div ? (DIV_LAT > 1) : (MUL_LAT > 1);

    assign STALL = !FLUSH && ((state_q == ST_MD_WAIT) || hazard);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bundle_q  <= CTRL_BUBBLE;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            bundle_q  <= CTRL_BUBBLE;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            if (FLUSH) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end else if (state_q == ST_MD_WAIT) begin
                if (cnt_q == CNT_ONE) begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q - CNT_ONE;
                end
            end else if (IN_VALID && !hazard) begin
                if (dec_illegal) begin
                    illegal_q <= 1'b1;
                end else begin
                    bundle_q <= dec_ctrl;
                    valid_q  <= 1'b1;
                    if (dec_is_md && md_multi) begin
                        state_q <= ST_MD_WAIT;
                        cnt_q   <= dec_md_div ? DIV_CNT : MUL_CNT;
                    end
                end
            end
        end
    end

    assign OUT_VALID  = valid_q;
    assign ILLEGAL    = illegal_q;
    assign ALU_OP     = bundle_q.alu_op;
    assign MEM_READ   = bundle_q.mem_read;
    assign MEM_WRITE  = bundle_q.mem_write;
    assign IMMI_SEL   = bundle_q.immi_sel;
    assign MEM_TO_REG = bundle_q.mem_to_reg;
    assign ALU_SOURCE = bundle_q.alu_source;
    assign REG_WRITE  = bundle_q.reg_write;
    assign BRANCH     = bundle_q.branch;
    assign PC_SEL     = bundle_q.pc_sel;
    assign RD         = bundle_q.rd;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: main instance with M-extension, second instance without.
module tb_pipe_ctrl_unit;

    localparam logic [31:0] I_ADD3  = 32'h002081B3; // add  x3,x1,x2
    localparam logic [31:0] I_LW5   = 32'h0000A283; // lw   x5,0(x1)
    localparam logic [31:0] I_ADD6  = 32'h00228333; // add  x6,x5,x2
    localparam logic [31:0] I_LW0   = 32'h0000A003; // lw   x0,0(x1)
    localparam logic [31:0] I_ADD60 = 32'h00200333; // add  x6,x0,x2
    localparam logic [31:0] I_DIV   = 32'h0220C3B3; // div  x7,x1,x2
    localparam logic [31:0] I_MUL   = 32'h02208433; // mul  x8,x1,x2
    localparam logic [31:0] I_SRAI  = 32'h4030D493; // srai x9,x1,3
    localparam logic [31:0] I_SH    = 32'h00209223; // sh   x2,4(x1)
    localparam logic [31:0] I_LHU   = 32'h0000D503; // lhu  x10,0(x1)
    localparam logic [31:0] I_BGE   = 32'h0020D463; // bge  x1,x2,8
    localparam logic [31:0] I_LUI   = 32'h123455B7; // lui  x11,0x12345
    localparam logic [31:0] I_BAD   = 32'h0000007F;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] INSTR;
    logic        IN_VALID;
    logic        FLUSH;

    logic       STALL, OUT_VALID, REG_WRITE, BRANCH, PC_SEL, ILLEGAL;
    logic [4:0] ALU_OP, RD;
    logic [2:0] MEM_READ, MEM_WRITE, IMMI_SEL;
    logic [1:0] MEM_TO_REG, ALU_SOURCE;

    logic       n_STALL, n_OUT_VALID, n_REG_WRITE, n_BRANCH, n_PC_SEL, n_ILLEGAL;
    logic [4:0] n_ALU_OP, n_RD;
    logic [2:0] n_MEM_READ, n_MEM_WRITE, n_IMMI_SEL;
    logic [1:0] n_MEM_TO_REG, n_ALU_SOURCE;

    int checks   = 0;
    int failures = 0;
    int n_stall;

    always #5 CLK = ~CLK;

    pipe_ctrl_unit #(.EN_MEXT(1'b1), .MUL_LAT(1), .DIV_LAT(8)) u_dut (
        .CLK(CLK), .RESET(RESET), .INSTR(INSTR), .IN_VALID(IN_VALID), .FLUSH(FLUSH),
        .STALL(STALL), .OUT_VALID(OUT_VALID), .ALU_OP(ALU_OP), .MEM_READ(MEM_READ),
        .MEM_WRITE(MEM_WRITE), .IMMI_SEL(IMMI_SEL), .MEM_TO_REG(MEM_TO_REG),
        .ALU_SOURCE(ALU_SOURCE), .REG_WRITE(REG_WRITE), .BRANCH(BRANCH),
        .PC_SEL(PC_SEL), .RD(RD), .ILLEGAL(ILLEGAL)
    );

    pipe_ctrl_unit #(.EN_MEXT(1'b0)) u_nom (
        .CLK(CLK), .RESET(RESET), .INSTR(INSTR), .IN_VALID(IN_VALID), .FLUSH(FLUSH),
        .STALL(n_STALL), .OUT_VALID(n_OUT_VALID), .ALU_OP(n_ALU_OP), .MEM_READ(n_MEM_READ),
        .MEM_WRITE(n_MEM_WRITE), .IMMI_SEL(n_IMMI_SEL), .MEM_TO_REG(n_MEM_TO_REG),
        .ALU_SOURCE(n_ALU_SOURCE), .REG_WRITE(n_REG_WRITE), .BRANCH(n_BRANCH),
        .PC_SEL(n_PC_SEL), .RD(n_RD), .ILLEGAL(n_ILLEGAL)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] ins, input logic v, input logic f);
        INSTR    = ins;
        IN_VALID = v;
        FLUSH    = f;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        RESET = 1'b0;
        drive(I_ADD3, 1'b1, 1'b0);
        tick();
        tick();
        chk("rst_valid",   32'(OUT_VALID), 32'h0);
        chk("rst_alu",     32'(ALU_OP),    32'h0);
        chk("rst_regwr",   32'(REG_WRITE), 32'h0);
        chk("rst_rd",      32'(RD),        32'h0);
        chk("rst_illegal", 32'(ILLEGAL),   32'h0);
        chk("rst_stall",   32'(STALL),     32'h0);

        RESET = 1'b1;
        #1;
        tick();
        chk("add_valid", 32'(OUT_VALID), 32'h1);
        chk("add_alu",   32'(ALU_OP),    32'h00);
        chk("add_regwr", 32'(REG_WRITE), 32'h1);
        chk("add_rd",    32'(RD),        32'h3);

        drive(I_LW5, 1'b1, 1'b0);
        chk("lw_stall", 32'(STALL), 32'h0);
        tick();
        chk("lw_memrd", 32'(MEM_READ),   32'h3);
        chk("lw_wb",    32'(MEM_TO_REG), 32'h1);
        chk("lw_rd",    32'(RD),         32'h5);

        drive(I_ADD6, 1'b1, 1'b0);
        chk("lu_stall", 32'(STALL), 32'h1);
        tick();
        chk("lu_bubble", 32'(OUT_VALID), 32'h0);
        chk("lu_stall_once", 32'(STALL), 32'h0);
        tick();
        chk("lu_issue_valid", 32'(OUT_VALID), 32'h1);
        chk("lu_issue_rd",    32'(RD),        32'h6);

        drive(I_LW0, 1'b1, 1'b0);
        tick();
        drive(I_ADD60, 1'b1, 1'b0);
        chk("x0_stall", 32'(STALL), 32'h0);
        tick();
        chk("x0_valid", 32'(OUT_VALID), 32'h1);

        drive(I_DIV, 1'b1, 1'b0);
        tick();
        chk("div_valid", 32'(OUT_VALID), 32'h1);
        chk("div_alu",   32'(ALU_OP),    32'h1C);
        chk("div_rd",    32'(RD),        32'h7);
        drive(I_ADD3, 1'b1, 1'b0);
        n_stall = 0;
        for (int i = 0; i < 12; i++) begin
            if (STALL !== 1'b1) break;
            n_stall++;
            tick();
        end
        chk("div_stall_cycles", 32'(n_stall), 32'd7);
        chk("div_last_bubble",  32'(OUT_VALID), 32'h0);
        tick();
        chk("div_after_valid", 32'(OUT_VALID), 32'h1);
        chk("div_after_rd",    32'(RD),        32'h3);

        drive(I_MUL, 1'b1, 1'b0);
        tick();
        chk("mul_alu",       32'(ALU_OP),      32'h18);
        chk("mul_valid",     32'(OUT_VALID),   32'h1);
        chk("nom_mul_ill",   32'(n_ILLEGAL),   32'h1);
        chk("nom_mul_valid", 32'(n_OUT_VALID), 32'h0);
        drive(I_ADD3, 1'b1, 1'b0);
        chk("mul_no_stall", 32'(STALL), 32'h0);
        tick();
        chk("mul_next_valid", 32'(OUT_VALID), 32'h1);
        chk("nom_ill_clear",  32'(n_ILLEGAL), 32'h0);

        drive(I_DIV, 1'b1, 1'b0);
        tick();
        drive(I_ADD3, 1'b1, 1'b0);
        chk("fl_md1_stall", 32'(STALL), 32'h1);
        tick();
        tick();
        drive(I_ADD3, 1'b1, 1'b1);
        chk("fl_md3_stall", 32'(STALL), 32'h0);
        tick();
        chk("fl_bubble", 32'(OUT_VALID), 32'h0);
        drive(I_ADD3, 1'b1, 1'b0);
        chk("fl_idle_stall", 32'(STALL), 32'h0);
        tick();
        chk("fl_resume", 32'(OUT_VALID), 32'h1);

        drive(I_LW5, 1'b1, 1'b0);
        tick();
        drive(I_ADD6, 1'b1, 1'b1);
        chk("fl_lu_stall", 32'(STALL), 32'h0);
        tick();
        chk("fl_lu_bubble", 32'(OUT_VALID), 32'h0);

        drive(I_SRAI, 1'b1, 1'b0);
        tick();
        chk("srai_alu", 32'(ALU_OP),     32'h15);
        chk("srai_imm", 32'(IMMI_SEL),   32'h1);
        chk("srai_src", 32'(ALU_SOURCE), 32'h1);

        drive(I_SH, 1'b1, 1'b0);
        tick();
        chk("sh_memwr", 32'(MEM_WRITE), 32'h2);
        chk("sh_regwr", 32'(REG_WRITE), 32'h0);

        drive(I_LHU, 1'b1, 1'b0);
        tick();
        chk("lhu_memrd", 32'(MEM_READ), 32'h5);

        drive(I_BGE, 1'b1, 1'b0);
        chk("bge_stall", 32'(STALL), 32'h0);
        tick();
        chk("bge_alu",    32'(ALU_OP), 32'h0D);
        chk("bge_branch", 32'(BRANCH), 32'h1);

        drive(I_LUI, 1'b1, 1'b0);
        tick();
        chk("lui_alu", 32'(ALU_OP), 32'h1E);

        drive(I_BAD, 1'b1, 1'b0);
        tick();
        chk("bad_illegal", 32'(ILLEGAL),   32'h1);
        chk("bad_valid",   32'(OUT_VALID), 32'h0);
        chk("bad_alu",     32'(ALU_OP),    32'h0);
        drive(I_BAD, 1'b0, 1'b0);
        chk("inv_stall", 32'(STALL), 32'h0);
        tick();
        chk("inv_illegal", 32'(ILLEGAL),   32'h0);
        chk("inv_valid",   32'(OUT_VALID), 32'h0);

        drive(I_DIV, 1'b1, 1'b0);
        tick();
        drive(I_ADD3, 1'b1, 1'b0);
        chk("rmd_stall", 32'(STALL), 32'h1);
        RESET = 1'b0;
        #1;
        tick();
        chk("rmd_valid", 32'(OUT_VALID), 32'h0);
        chk("rmd_stall_after", 32'(STALL), 32'h0);
        RESET = 1'b1;
        #1;
        chk("rmd_release_stall", 32'(STALL), 32'h0);
        tick();
        chk("rmd_issue_valid", 32'(OUT_VALID), 32'h1);
        chk("rmd_issue_rd",    32'(RD),        32'h3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
